// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions: scan-code prefixes, FSM states, event record layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

   // Prefix bytes sent by the keyboard ahead of the actual scan code
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // Frame receive FSM, advanced only on filtered PS/2 clock falling edges
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Event record layout as stored in the FIFO: {ext, brk, code[7:0]}
   localparam int EVT_W        = 10;
   localparam int EVT_CODE_LSB = 0;
   localparam int EVT_CODE_W   = 8;
   localparam int EVT_BRK_BIT  = 8;
   localparam int EVT_EXT_BIT  = 9;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
   function automatic logic parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 pin conditioning: 2-flop synchronisers, FILT_LEN-sample clock glitch filter, falling-edge strobe.
// Latency: 2 sync cycles + FILT_LEN filter cycles + 1 strobe register from pin edge to oFall.
// Backpressure: none; free-running, strobe is a single-cycle pulse.
module ps2_clk_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic iClock,
   input  logic iReset,
   input  logic iPS2_CLK,
   input  logic iPS2_DAT,
   output logic oFall,
   output logic oDat
);

   logic                clk_s1_q, clk_s2_q;
   logic                dat_s1_q, dat_s2_q;
   logic [FILT_LEN-1:0] filt_sh_q, filt_sh_d;
   logic                level_q, level_d;
   logic                fall_q, fall_d;

   // Filtered level only moves when the whole sample window agrees; a falling move raises the strobe
   always_comb begin
      filt_sh_d = {filt_sh_q[FILT_LEN-2:0], clk_s2_q};
      level_d   = level_q;
      if (&filt_sh_q) begin
         level_d = 1'b1;
      end else if (~|filt_sh_q) begin
         level_d = 1'b0;
      end
      fall_d = level_q & ~level_d;
   end

   // Synchronisers, filter window and strobe; idle bus level is high, so reset everything to 1
   always_ff @(posedge iClock) begin
      if (iReset) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         dat_s1_q  <= 1'b1;
         dat_s2_q  <= 1'b1;
         filt_sh_q <= '1;
         level_q   <= 1'b1;
         fall_q    <= 1'b0;
      end else begin
         clk_s1_q  <= iPS2_CLK;
         clk_s2_q  <= clk_s1_q;
         dat_s1_q  <= iPS2_DAT;
         dat_s2_q  <= dat_s1_q;
         filt_sh_q <= filt_sh_d;
         level_q   <= level_d;
         fall_q    <= fall_d;
      end
   end

   // Data is stable for many microseconds around the clock edge, so the plain synchronised value is used
   assign oFall = fall_q;
   assign oDat  = dat_s2_q;

endmodule

// File: rtl/ps2_scan_rx_fifo.sv
// PS/2 device-to-host receiver with E0/F0 prefix tracking and a FWFT event FIFO (PS2_WATCHDOG_EN adds frame watchdog).
// Latency: event pushed 1 cycle after the stop-bit strobe; oEvt_valid rises the cycle after the push.
// Backpressure: oEvt_valid/iEvt_ready drain; when full and not popped, new events are dropped and oOverflow sticks.
module ps2_scan_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FILT_LEN    = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic                          iPS2_CLK,
   input  logic                          iPS2_DAT,
   output logic [7:0]                    oEvt_code,
   output logic                          oEvt_break,
   output logic                          oEvt_ext,
   output logic                          oEvt_valid,
   input  logic                          iEvt_ready,
   output logic [$clog2(FIFO_DEPTH):0]   oFifo_count,
   output logic                          oErr_parity,
   output logic                          oErr_frame,
   output logic                          oOverflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // Elaboration-time guard against parameter values the logic cannot support
   if (FILT_LEN < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2)
   begin : g_param_check
      $error("ps2_scan_rx_fifo: illegal parameter value");
   end

   logic fall;
   logic dat;

   ps2_clk_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_filter (
      .iClock   (iClock),
      .iReset   (iReset),
      .iPS2_CLK (iPS2_CLK),
      .iPS2_DAT (iPS2_DAT),
      .oFall    (fall),
      .oDat     (dat)
   );

   ps2_state_e state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shreg_q;
   logic       par_q;
   logic       byte_vld_q;
   logic       err_par_q;
   logic       err_frm_q;
   logic       wd_expire;

`ifdef PS2_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   // Watchdog counts idle time between edges of an open frame; any edge or IDLE restarts it
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (fall || state_q == ST_IDLE) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LAST) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
      wd_expire = (state_q != ST_IDLE) && (wd_cnt_q == WD_LAST) && !fall;
   end

   // Watchdog counter register
   always_ff @(posedge iClock) begin
      if (iReset) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end
`else
   // Without the watchdog a truncated frame simply waits for more edges or a reset
   assign wd_expire = 1'b0;
`endif

   // Frame receive FSM: start, 8 data bits LSB first, parity, stop; outputs are registered pulses
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         byte_vld_q <= 1'b0;
         err_par_q  <= 1'b0;
         err_frm_q  <= 1'b0;
      end else begin
         byte_vld_q <= 1'b0;
         err_par_q  <= 1'b0;
         err_frm_q  <= 1'b0;
         if (wd_expire) begin
            state_q   <= ST_IDLE;
            err_frm_q <= 1'b1;
         end else if (fall) begin
            case (state_q)
               ST_IDLE: begin
                  // A high data line at a falling edge is a spurious start and is ignored
                  if (!dat) begin
                     state_q   <= ST_DATA;
                     bit_cnt_q <= '0;
                  end
               end
               ST_DATA: begin
                  shreg_q[bit_cnt_q] <= dat;
                  bit_cnt_q          <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  par_q   <= dat;
                  state_q <= ST_STOP;
               end
               ST_STOP: begin
                  state_q <= ST_IDLE;
                  if (!dat) begin
                     err_frm_q <= 1'b1;
                  end else if (!parity_ok(shreg_q, par_q)) begin
                     err_par_q <= 1'b1;
                  end else begin
                     byte_vld_q <= 1'b1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   logic             ext_q, ext_d;
   logic             brk_q, brk_d;
   logic             push;
   logic [EVT_W-1:0] push_evt;

   // Prefix tracking: E0/F0 only set flags, any other good byte becomes an event; errors forget prefixes
   always_comb begin
      ext_d    = ext_q;
      brk_d    = brk_q;
      push     = 1'b0;
      push_evt = '0;
      push_evt[EVT_EXT_BIT]                   = ext_q;
      push_evt[EVT_BRK_BIT]                   = brk_q;
      push_evt[EVT_CODE_LSB +: EVT_CODE_W]    = shreg_q;
      if (err_par_q || err_frm_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (byte_vld_q) begin
         if (shreg_q == SC_EXT) begin
            ext_d = 1'b1;
         end else if (shreg_q == SC_BREAK) begin
            brk_d = 1'b1;
         end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
         end
      end
   end

   // Prefix flag registers
   always_ff @(posedge iClock) begin
      if (iReset) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
         brk_q <= brk_d;
      end
   end

   logic [EVT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop_ok;
   logic             push_ok;

   // FIFO control: a pop frees the slot a same-cycle push needs, so full+pop+push is accepted
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == FULL_CNT);
      pop_ok     = iEvt_ready && !fifo_empty;
      push_ok    = push && (!fifo_full || pop_ok);
      wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d   = pop_ok  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d    = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q || (push && !push_ok);
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge iClock) begin
      if (iReset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Event storage without reset so it maps onto distributed RAM
   always_ff @(posedge iClock) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= push_evt;
      end
   end

   logic [EVT_W-1:0] head;

   // Fall-through head; gated so the event outputs read zero while empty and after reset
   always_comb begin
      head        = mem[rd_ptr_q];
      oEvt_valid  = !fifo_empty;
      oEvt_code   = fifo_empty ? 8'h00 : head[EVT_CODE_LSB +: EVT_CODE_W];
      oEvt_break  = !fifo_empty && head[EVT_BRK_BIT];
      oEvt_ext    = !fifo_empty && head[EVT_EXT_BIT];
      oFifo_count = count_q;
      oErr_parity = err_par_q;
      oErr_frame  = err_frm_q;
      oOverflow   = ovf_q;
   end

endmodule

// File: tb/tb_ps2_scan_rx_fifo.sv
// Self-checking bench for ps2_scan_rx_fifo: directed frames, glitches, overflow and randomised key traffic
// against a byte-level reference model (prefix flags + bounded event queue).
module tb_ps2_scan_rx_fifo;

   localparam int FILT  = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 1000;
   localparam int HALF  = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] evt_code;
   logic       evt_break, evt_ext, evt_valid;
   logic [2:0] fifo_count;
   logic       err_parity, err_frame, overflow;

   ps2_scan_rx_fifo #(
      .FILT_LEN    (FILT),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .iClock      (clk),
      .iReset      (rst),
      .iPS2_CLK    (ps2_clk),
      .iPS2_DAT    (ps2_dat),
      .oEvt_code   (evt_code),
      .oEvt_break  (evt_break),
      .oEvt_ext    (evt_ext),
      .oEvt_valid  (evt_valid),
      .iEvt_ready  (ready),
      .oFifo_count (fifo_count),
      .oErr_parity (err_parity),
      .oErr_frame  (err_frame),
      .oOverflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int n_perr = 0;
   int n_ferr = 0;
   int lat = 0;

   // error pulses counted as high cycles, so a stretched pulse shows up as an extra count
   always @(negedge clk) begin
      if (err_parity) n_perr++;
      if (err_frame)  n_ferr++;
   end

   // reference model: prefix flags, bounded event queue, sticky overflow
   bit         m_ext = 0, m_brk = 0, m_ovf = 0;
   logic [9:0] m_q[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_byte(input logic [7:0] b, input bit ok);
      if (!ok) begin
         m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         if (m_q.size() < DEPTH) m_q.push_back({m_ext, m_brk, b});
         else                    m_ovf = 1;
         m_ext = 0; m_brk = 0;
      end
   endtask

   // drive one device-to-host frame; nbits<11 truncates it, pop_dly>0 pulses ready after the stop fall
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch,
                             input int nbits, input int pop_dly, input bit measure);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         if (glitch && i >= 2 && i <= 8) begin
            wait_cyc(HALF/2 - 2);
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(HALF/2);
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b0;
         if (i == 10 && measure) begin
            lat = 0;
            for (int k = 1; k < HALF; k++) begin
               wait_cyc(1);
               if (evt_valid && lat == 0) lat = k;
            end
            wait_cyc(1);
         end else if (i == 10 && pop_dly > 0) begin
            wait_cyc(pop_dly);
            ready = 1'b1;
            wait_cyc(1);
            ready = 1'b0;
            wait_cyc(HALF - pop_dly - 1);
         end else begin
            wait_cyc(HALF);
         end
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
      wait_cyc(2*HALF);
   endtask

   task automatic key(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
      send_frame(b, bad_par, bad_stop, glitch, 11, 0, 0);
      m_byte(b, !bad_par && !bad_stop);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_cnt"}, 32'(fifo_count), 32'(m_q.size()));
      chk({tag, "_vld"}, 32'(evt_valid), 32'(m_q.size() > 0));
      chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
      if (m_q.size() > 0) begin
         chk({tag, "_code"}, 32'(evt_code),  32'(m_q[0][7:0]));
         chk({tag, "_brk"},  32'(evt_break), 32'(m_q[0][8]));
         chk({tag, "_ext"},  32'(evt_ext),   32'(m_q[0][9]));
      end
   endtask

   task automatic drain(input string tag);
      int guard;
      guard = 0;
      while (m_q.size() > 0 && guard < 2*DEPTH) begin
         check_state(tag);
         ready = 1'b1;
         wait_cyc(1);
         ready = 1'b0;
         void'(m_q.pop_front());
         guard++;
      end
      chk({tag, "_empty_cnt"}, 32'(fifo_count), 32'd0);
      chk({tag, "_empty_vld"}, 32'(evt_valid), 32'd0);
      ready = 1'b1;
      wait_cyc(1);
      ready = 1'b0;
      chk({tag, "_pop_empty"}, 32'(fifo_count), 32'd0);
   endtask

   int p0, f0, t0;
   logic [7:0] rc;
   bit bp, bs, gl;

   initial begin
      rst = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(1);
      chk("rst_vld",  32'(evt_valid),  32'd0);
      chk("rst_cnt",  32'(fifo_count), 32'd0);
      chk("rst_code", 32'(evt_code),   32'd0);
      chk("rst_brk",  32'(evt_break),  32'd0);
      chk("rst_ext",  32'(evt_ext),    32'd0);
      chk("rst_perr", 32'(err_parity), 32'd0);
      chk("rst_ferr", 32'(err_frame),  32'd0);
      chk("rst_ovf",  32'(overflow),   32'd0);

      // single key 0x1C, latency from stop-bit falling edge to valid
      send_frame(8'h1C, 0, 0, 0, 11, 0, 1);
      m_byte(8'h1C, 1);
      chk("t1_lat_bound", 32'(lat > FILT + 2 && lat < HALF), 32'd1);
      check_state("t1");
      drain("t1_drain");

      // break and extended-break sequences; prefixes alone push nothing
      key(8'hF0, 0, 0, 0);
      check_state("t2_pfx");
      key(8'h1C, 0, 0, 0);
      key(8'hE0, 0, 0, 0);
      key(8'hF0, 0, 0, 0);
      check_state("t2_pfx2");
      key(8'h75, 0, 0, 0);
      check_state("t2");
      drain("t2_drain");

      // parity error, prefix survives nothing, stop error
      p0 = n_perr;
      key(8'h1C, 1, 0, 0);
      chk("t3_perr", 32'(n_perr), 32'(p0 + 1));
      check_state("t3_nopush");
      key(8'hF0, 0, 0, 0);
      key(8'h1C, 0, 0, 0);
      check_state("t3_after");
      key(8'hE0, 0, 0, 0);
      key(8'h55, 1, 0, 0);
      key(8'h1C, 0, 0, 0);
      check_state("t3_clr");
      f0 = n_ferr;
      key(8'h1C, 0, 1, 0);
      chk("t3_ferr", 32'(n_ferr), 32'(f0 + 1));
      check_state("t3_stop");
      drain("t3_drain");

      // short clock glitches inside frames
      key(8'h5A, 0, 0, 1);
      key(8'hE0, 0, 0, 1);
      key(8'h6B, 0, 0, 1);
      check_state("t5");
      drain("t5_drain");

      // overflow, then full + simultaneous pop/push
      for (int i = 0; i < 5; i++) key(8'(8'h11 + i), 0, 0, 0);
      check_state("t4_full");
      send_frame(8'h16, 0, 0, 0, 11, lat - 1, 0);
      void'(m_q.pop_front());
      m_byte(8'h16, 1);
      check_state("t4_poppush");
      drain("t4_drain");

      // randomised key traffic with occasional bad frames and glitches
      for (int n = 0; n < 40; n++) begin
         rc = 8'($urandom_range(1, 127));
         case ($urandom % 4)
            1: key(8'hF0, 0, 0, 0);
            2: key(8'hE0, 0, 0, 0);
            3: begin key(8'hE0, 0, 0, 0); key(8'hF0, 0, 0, 0); end
            default: ;
         endcase
         bp = ($urandom % 12) == 0;
         bs = !bp && (($urandom % 12) == 0);
         gl = ($urandom % 4) == 0;
         key(rc, bp, bs, gl);
         check_state("rnd");
         if ($urandom % 3 == 0) drain("rnd_drain");
      end
      drain("rnd_final");

`ifdef PS2_WATCHDOG_EN
      // truncated frame after an E0 prefix: watchdog aborts it and clears the prefix
      key(8'hE0, 0, 0, 0);
      f0 = n_ferr;
      send_frame(8'h2B, 0, 0, 0, 5, 0, 0);
      wait_cyc(TMO - 100);
      chk("wd_early", 32'(n_ferr), 32'(f0));
      t0 = 0;
      while (n_ferr == f0 && t0 < 300) begin
         wait_cyc(1);
         t0++;
      end
      chk("wd_abort", 32'(n_ferr), 32'(f0 + 1));
      m_byte(8'h00, 0);
      key(8'h2B, 0, 0, 0);
      check_state("wd_next");
      drain("wd_drain");
`endif

      // reset in the middle of a frame with events queued
      key(8'h33, 0, 0, 0);
      key(8'h34, 0, 0, 0);
      check_state("mr_pre");
      send_frame(8'h44, 0, 0, 0, 5, 0, 0);
      rst = 1'b1;
      wait_cyc(1);
      chk("mr_vld",  32'(evt_valid),  32'd0);
      chk("mr_cnt",  32'(fifo_count), 32'd0);
      chk("mr_code", 32'(evt_code),   32'd0);
      chk("mr_ovf",  32'(overflow),   32'd0);
      chk("mr_errs", 32'({err_parity, err_frame, evt_break, evt_ext}), 32'd0);
      rst = 1'b0;
      m_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0;
      wait_cyc(2);
      key(8'h1C, 0, 0, 0);
      check_state("mr_next");
      drain("mr_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
